// File: rtl/nco_iq_stream.sv
// Unpacks a packed DDS/NCO word into signed I/Q samples with mode control,
// width conversion (round-half-up + saturation) and a 2-entry skid buffer.
module nco_iq_stream #(
  parameter int I_WIDTH = 32,
  parameter int F_WIDTH = I_WIDTH / 2,
  parameter int D_WIDTH = 12,
  parameter int O_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [I_WIDTH-1:0] NCO_tdata,
  input  logic               NCO_tvalid,
  output logic               NCO_tready,
  output logic [O_WIDTH-1:0] NCO_cos,
  output logic [O_WIDTH-1:0] NCO_sin,
  output logic               NCO_vld,
  input  logic               NCO_rdy,
  output logic [15:0]        sat_cnt
);

  localparam int XW     = D_WIDTH + 1;
  localparam int WW     = D_WIDTH + O_WIDTH + 2;
  localparam int SH_R   = (O_WIDTH < D_WIDTH) ? D_WIDTH - O_WIDTH : 0;
  localparam int SH_L   = (O_WIDTH > D_WIDTH) ? O_WIDTH - D_WIDTH : 0;
  localparam int SH_RM1 = (SH_R > 0) ? SH_R - 1 : 0;
  localparam logic signed [WW-1:0] RND  = (SH_R > 0) ? (WW'(1) << SH_RM1) : {WW{1'b0}};
  localparam logic signed [WW-1:0] MAXV = {{(WW-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  // Returns {saturated, value}; wide intermediate keeps rounding carry and negation overflow.
  function automatic logic [O_WIDTH:0] conv(input logic signed [XW-1:0] x);
    logic signed [WW-1:0] w;
    w = {{(WW-XW){x[XW-1]}}, x};
    if (SH_R > 0) w = (w + RND) >>> SH_R;
    else          w = w <<< SH_L;
    if (w > MAXV)      conv = {1'b1, MAXV[O_WIDTH-1:0]};
    else if (w < MINV) conv = {1'b1, MINV[O_WIDTH-1:0]};
    else               conv = {1'b0, w[O_WIDTH-1:0]};
  endfunction

  logic [D_WIDTH-1:0]      c_raw, s_raw;
  logic signed [XW-1:0]    c_x, s_x, c_m, s_m;
  logic [O_WIDTH:0]        c_conv, s_conv;
  logic                    sat_flag;
  logic                    accept;
  logic [O_WIDTH-1:0]      skid_cos, skid_sin;
  logic                    skid_vld;

  always_comb begin
    c_raw = NCO_tdata[D_WIDTH-1:0];
    s_raw = NCO_tdata[F_WIDTH +: D_WIDTH];
    c_x   = {c_raw[D_WIDTH-1], c_raw};
    s_x   = {s_raw[D_WIDTH-1], s_raw};
    c_m   = c_x;
    s_m   = s_x;
    case (mode)
      2'b00:   ;
      2'b01:   s_m = -s_x;
      2'b10:   begin c_m = s_x; s_m = c_x; end
      default: begin c_m = '0;  s_m = '0;  end
    endcase
    c_conv   = conv(c_m);
    s_conv   = conv(s_m);
    sat_flag = c_conv[O_WIDTH] | s_conv[O_WIDTH];
    accept   = NCO_tvalid & NCO_tready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      NCO_cos    <= '0;
      NCO_sin    <= '0;
      NCO_vld    <= 1'b0;
      skid_cos   <= '0;
      skid_sin   <= '0;
      skid_vld   <= 1'b0;
      NCO_tready <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      NCO_tready <= ~skid_vld;
      // Output slot is free (or being consumed): refill from skid first, then from input.
      if (!NCO_vld || NCO_rdy) begin
        if (skid_vld) begin
          NCO_cos    <= skid_cos;
          NCO_sin    <= skid_sin;
          NCO_vld    <= 1'b1;
          skid_vld   <= 1'b0;
          NCO_tready <= 1'b1;
        end else if (accept) begin
          NCO_cos <= c_conv[O_WIDTH-1:0];
          NCO_sin <= s_conv[O_WIDTH-1:0];
          NCO_vld <= 1'b1;
        end else begin
          NCO_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_cos   <= c_conv[O_WIDTH-1:0];
        skid_sin   <= s_conv[O_WIDTH-1:0];
        skid_vld   <= 1'b1;
        NCO_tready <= 1'b0;
      end
      if (accept && sat_flag && (sat_cnt != '1))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_nco_iq_stream.sv
// Scoreboard bench for nco_iq_stream: default 12-bit output and a 10-bit
// rounding instance share one stimulus stream and one expectation queue.
module tb_nco_iq_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        rdy = 1'b0;
  logic        trdy_a, trdy_b, vld_a, vld_b;
  logic [11:0] cos_a, sin_a;
  logic [9:0]  cos_b, sin_b;
  logic [15:0] sat_a, sat_b;

  always #5 clk = ~clk;

  nco_iq_stream u_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .NCO_tdata(tdata), .NCO_tvalid(tvalid),
    .NCO_tready(trdy_a), .NCO_cos(cos_a), .NCO_sin(sin_a), .NCO_vld(vld_a),
    .NCO_rdy(rdy), .sat_cnt(sat_a)
  );

  nco_iq_stream #(.O_WIDTH(10)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .NCO_tdata(tdata), .NCO_tvalid(tvalid),
    .NCO_tready(trdy_b), .NCO_cos(cos_b), .NCO_sin(sin_b), .NCO_vld(vld_b),
    .NCO_rdy(rdy), .sat_cnt(sat_b)
  );

  typedef struct { int c12; int s12; int c10; int s10; } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_sat12 = 0, m_sat10 = 0;
  int   cyc = 0;
  bit   chk_en = 0, rst_prev = 0, rand_rdy = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_n;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sext12(input logic [11:0] v);
    return v[11] ? int'(v) - 4096 : int'(v);
  endfunction

  // Plain-arithmetic reference: scale a 12-bit-significant value to ow bits.
  function automatic void ref_scale(input int x, input int ow, output int y, output bit sat);
    int hi, lo;
    if (ow < 12) y = (x + (1 << (11 - ow))) >>> (12 - ow);
    else         y = x * (1 << (ow - 12));
    hi  = (1 << (ow - 1)) - 1;
    lo  = -(1 << (ow - 1));
    sat = (y > hi) || (y < lo);
    if (y > hi) y = hi;
    if (y < lo) y = lo;
  endfunction

  function automatic void model(input logic [31:0] w, input logic [1:0] m,
                                output exp_t e, output bit s12, output bit s10);
    int c, s, t;
    bit a, b;
    c = sext12(w[11:0]);
    s = sext12(w[27:16]);
    case (m)
      2'd1: s = -s;
      2'd2: begin t = c; c = s; s = t; end
      2'd3: begin c = 0; s = 0; end
      default: ;
    endcase
    ref_scale(c, 12, e.c12, a); ref_scale(s, 12, e.s12, b); s12 = a | b;
    ref_scale(c, 10, e.c10, a); ref_scale(s, 10, e.s10, b); s10 = a | b;
  endfunction

  // Input side: records each word the coming edge will accept.
  always @(negedge clk) begin
    exp_t e;
    bit   s12, s10;
    #1;
    if (chk_en) begin
      check("sat_cnt_12", int'(sat_a), m_sat12);
      check("sat_cnt_10", int'(sat_b), m_sat10);
      if (!rst_n) begin
        q.delete();
        m_sat12 = 0;
        m_sat10 = 0;
      end else if (tvalid && trdy_a) begin
        model(tdata, mode, e, s12, s10);
        q.push_back(e);
        if (s12 && m_sat12 < 65535) m_sat12++;
        if (s10 && m_sat10 < 65535) m_sat10++;
      end
    end
  end

  // Output side: occupancy, ordering and hold-while-stalled.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en && rst_prev) begin
      check("vld_12", int'(vld_a), int'(q.size() > 0));
      check("vld_10", int'(vld_b), int'(q.size() > 0));
      check("tready_12", int'(trdy_a), int'(q.size() < 2));
      check("tready_10", int'(trdy_b), int'(q.size() < 2));
      if (vld_a && q.size() > 0) begin
        e = q[0];
        check("cos_12", int'($signed(cos_a)), e.c12);
        check("sin_12", int'($signed(sin_a)), e.s12);
        check("cos_10", int'($signed(cos_b)), e.c10);
        check("sin_10", int'($signed(sin_b)), e.s10);
        if (rdy && rst_n) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [1:0] m);
    bit acc;
    int budget;
    budget = 0;
    tvalid = 1'b1; tdata = w; mode = m;
    do begin
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      acc = trdy_a;
      @(posedge clk); #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) check("send_timeout", 0, 1);
    tvalid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    rdy = 1'b1;
    while (q.size() > 0 && b < 100) begin @(posedge clk); #1; b++; end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int t0, n, b, sat_prev;
    bit acc;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_vld", int'(vld_a), 0);
    check("rst_tready", int'(trdy_a), 0);
    check("rst_cos", int'(cos_a), 0);
    check("rst_sin", int'(sin_a), 0);
    check("rst_sat", int'(sat_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("tready_after_rst", int'(trdy_a), 1);
    rdy = 1'b1;

    send(32'h0F00_07FF, 2'd0);
    check("norm_cos", int'($signed(cos_a)), 2047);
    check("norm_sin", int'($signed(sin_a)), -256);
    send(32'h0800_0000, 2'd1);
    check("conj_sat_sin", int'($signed(sin_a)), 2047);
    check("conj_sat_cnt", int'(sat_a), 1);
    send(32'h0F00_0000, 2'd1);
    check("conj_sin", int'($signed(sin_a)), 256);
    send(32'h0F00_07FF, 2'd2);
    check("swap_cos", int'($signed(cos_a)), -256);
    check("swap_sin", int'($signed(sin_a)), 2047);
    send(32'h0F00_07FF, 2'd3);
    check("mute_cos", int'($signed(cos_a)), 0);
    check("mute_sin", int'($signed(sin_a)), 0);
    check("mute_vld", int'(vld_a), 1);

    send(32'h0000_0005, 2'd0);
    check("rnd_5", int'($signed(cos_b)), 1);
    send(32'h0000_0FFA, 2'd0);
    check("rnd_m6", int'($signed(cos_b)), -1);
    sat_prev = int'(sat_b);
    send(32'h0000_07FF, 2'd0);
    check("rnd_2047", int'($signed(cos_b)), 511);
    check("rnd_sat_inc", int'(sat_b), sat_prev + 1);
    send(32'h0000_0002, 2'd0);
    check("rnd_half_up", int'($signed(cos_b)), 1);

    t0 = cyc;
    repeat (100) send($urandom, 2'($urandom_range(0, 3)));
    check("throughput_cycles", cyc - t0, 100);
    rand_rdy = 1;
    repeat (100) send($urandom, 2'($urandom_range(0, 3)));
    rand_rdy = 0;
    drain();

    // Continuous stream into a stalled output: only two words fit.
    rdy = 1'b0; n = 0;
    tvalid = 1'b1; tdata = $urandom; mode = 2'd0;
    repeat (5) begin
      acc = trdy_a;
      @(posedge clk); #1;
      if (acc) begin n++; tdata = $urandom; end
    end
    check("bp_buffered", n, 2);
    check("bp_tready_low", int'(trdy_a), 0);
    rdy = 1'b1; b = 0;
    while (n < 6 && b < 50) begin
      acc = trdy_a;
      @(posedge clk); #1;
      if (acc) begin n++; tdata = $urandom; end
      b++;
    end
    tvalid = 1'b0;
    check("bp_resume", n, 6);
    drain();

    rdy = 1'b0;
    send(32'h0123_0456, 2'd0);
    send(32'h0789_0ABC, 2'd1);
    check("stall_tready", int'(trdy_a), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld", int'(vld_a), 0);
    check("midrst_tready", int'(trdy_a), 0);
    check("midrst_vld_10", int'(vld_b), 0);
    rst_n = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    check("midrst_tready_up", int'(trdy_a), 1);
    check("midrst_empty", int'(vld_a), 0);
    send(32'h0A5A_05A5, 2'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_iq_stream.md
Name: nco_iq_stream

Overview:
- Parametrised successor to the single-register NCO cos/sin splitter. It unpacks a packed DDS/NCO AXI-Stream word into signed I (cos) and Q (sin) samples.
- Adds a runtime mode (normal / conjugate / swap / mute), width conversion with round-half-up and saturation, and full valid/ready backpressure through a 2-entry skid buffer.
- Sits between the DDS IP and the mixer/demodulator datapath.

Parameters:
- I_WIDTH, 32: packed input word width. Must be even.
- F_WIDTH, I_WIDTH/2: field stride. Cos field starts at bit 0, sin field starts at bit F_WIDTH.
- D_WIDTH, 12: significant signed bits in each field (bits D_WIDTH-1:0 of the field). D_WIDTH <= F_WIDTH.
- O_WIDTH, 12: signed output width. Range 2..24.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  00 normal, 01 conjugate (Q negated), 10 swap I/Q, 11 mute (zeros, valid still flows). Sampled at input acceptance.
- NCO_tdata  in  I_WIDTH  packed DDS word.
- NCO_tvalid  in  1  input valid.
- NCO_tready  out  1  input ready.
- NCO_cos  out  O_WIDTH  signed I sample.
- NCO_sin  out  O_WIDTH  signed Q sample.
- NCO_vld  out  1  output valid.
- NCO_rdy  in  1  downstream ready.
- sat_cnt  out  16  count of saturated samples. Saturates at 0xFFFF.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - NCO_cos, NCO_sin and sat_cnt are 0; NCO_vld and NCO_tready are 0.
  - The skid buffer is emptied, so in-flight samples are discarded. Reset mid-transfer drops data silently.
  - NCO_tready goes to 1 on the first edge with rst_n=1.
- Accept and emit:
  - The input is accepted on an edge with NCO_tvalid & NCO_tready.
  - The output is consumed on an edge with NCO_vld & NCO_rdy.
  - Latency is 1 cycle: a sample accepted at edge k is visible at the output after edge k.
  - Throughput is 1 sample per cycle while NCO_rdy=1.
- Skid buffer:
  - Two entries: the output register plus one skid register.
  - NCO_tready is registered and equals "skid register empty".
  - With NCO_vld=1 and NCO_rdy=0, one more accepted word goes to the skid register; NCO_tready then drops on the next edge.
  - When NCO_rdy returns, the skid entry moves to the output register and NCO_tready rises on the next edge.
  - Simultaneous accept and consume with an empty skid register keeps the pipeline flowing and never uses the skid register.
  - Ordering is strictly FIFO. No word is dropped or duplicated.
  - Outputs hold stable while NCO_vld=1 and NCO_rdy=0.
- Datapath, per field, applied before buffering:
  - Extract: c = tdata[D_WIDTH-1:0] and s = tdata[F_WIDTH+D_WIDTH-1:F_WIDTH], both signed.
  - Mode is applied at D_WIDTH+1 bits: conjugate gives s=-s; swap exchanges c and s; mute gives c=s=0.
  - If O_WIDTH < D_WIDTH, with sh = D_WIDTH-O_WIDTH: the result is (x + 2^(sh-1)) >>> sh, then saturated to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
  - If O_WIDTH >= D_WIDTH: the result is x <<< (O_WIDTH-D_WIDTH), saturated, since the negated -2^(D_WIDTH-1) can overflow.
  - The saturation flag is the OR of both channels.
- sat_cnt:
  - Increments by 1 per accepted input word with the saturation flag set.
  - Counts at acceptance, not at output.
  - Holds at 0xFFFF once reached.
- Mode changes take effect on the next accepted word. Already-buffered words keep the mode they were accepted with.

Test Plan:
- Reset and ready:
  - Hold rst_n=0 for 3 cycles, then release -> all outputs 0 during reset; NCO_tready=1 one edge after release.
- Normal passthrough (defaults), with NCO_rdy=1:
  - Drive tdata=32'h0F00_07FF -> next cycle NCO_cos=2047 (0x7FF), NCO_sin=-256 (0xF00), NCO_vld=1.
  - Streaming 100 random words gives 100 in-order outputs at 1 word/cycle.
- Conjugate and saturation (mode=01):
  - Sin field 0x800 (-2048) -> NCO_sin=2047 and sat_cnt increments to 1.
  - Sin field 0xF00 -> NCO_sin=256.
- Swap and mute:
  - mode=10 with 32'h0F00_07FF -> NCO_cos=-256, NCO_sin=2047.
  - mode=11 -> both outputs 0 with NCO_vld=1.
- Rounding (O_WIDTH=10):
  - cos field 5 -> 1; field -6 -> -1; field 2047 -> 511 (saturated, sat_cnt+1); field 2 -> 1 (half-up).
- Backpressure:
  - Stream continuously and hold NCO_rdy=0 for 5 cycles -> exactly 2 words buffered; NCO_tready=0 after the second.
  - Release NCO_rdy -> words emerge in order with no loss or duplication.
  - Assert rst_n=0 mid-stall -> NCO_vld=0 and the buffer is empty after one edge.
